// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing counters, sync generation and a run-time
// selectable test-pattern generator (stripes, colour bars, checkerboard,
// moving bar). All outputs are registered one clock behind the counters.
// Optional build macro VGA_PATTERN_BORDER_EN adds a 1-pixel white border
// that overrides every pattern.
module vga_pattern_gen #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0,
  parameter int STRIPE_SHIFT = 4,
  parameter int STEP         = 4,
  parameter int CW           = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [2:0]    mode,
  output logic          hsync,
  output logic          vsync,
  output logic [2:0]    red,
  output logic [2:0]    green,
  output logic [1:0]    blue,
  output logic          vidon,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CW + 1;
  localparam int BAR_W   = H_VISIBLE / 8;
  localparam int BAR_SZ  = 1 << STRIPE_SHIFT;

  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic          HS_LVL   = 1'(HS_POL);
  localparam logic          VS_LVL   = 1'(VS_POL);

  // RGB 3-3-2 packed colours
  localparam logic [7:0] C_WHITE   = 8'hFF;
  localparam logic [7:0] C_YELLOW  = 8'hFC;
  localparam logic [7:0] C_CYAN    = 8'h1F;
  localparam logic [7:0] C_GREEN   = 8'h1C;
  localparam logic [7:0] C_MAGENTA = 8'hE3;
  localparam logic [7:0] C_RED     = 8'hE0;
  localparam logic [7:0] C_BLUE    = 8'h03;
  localparam logic [7:0] C_BLACK   = 8'h00;

  // Frame-level state
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] pos_q,  pos_d;

  // Registered outputs
  logic          hsync_q, vsync_q, vidon_q, frame_start_q;
  logic [7:0]    rgb_q;
  logic [CW-1:0] hc_q, vc_q;

  // Next-output values computed from the current counters
  logic          hsync_d, vsync_d, vis, frame_start_d;
  logic [7:0]    rgb_d;

  logic          line_end, frame_end;
  logic [CW:0]   pos_sum, pos_hi;
  logic [2:0]    bar_idx;
  logic          in_bar;

  assign line_end  = (hcnt_q == H_LAST);
  assign frame_end = line_end && (vcnt_q == V_LAST);
  assign pos_sum   = {1'b0, pos_q} + CW1'(STEP);
  assign pos_hi    = {1'b0, pos_q} + CW1'(BAR_SZ);

  function automatic logic [7:0] bar_colour(input logic [2:0] k);
    case (k)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

  // Counter advance plus frame-boundary latching of mode and bar position
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hcnt_d = hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    mode_d = mode_q;
    pos_d  = pos_q;
    if (line_end) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
    end
    if (frame_end) begin
      mode_d = mode;
      pos_d  = (pos_sum >= CW1'(H_VISIBLE)) ? CW'(pos_sum - CW1'(H_VISIBLE))
                                            : CW'(pos_sum);
    end
  end

  // Sync, visibility and pattern selection for the current counter position
  always_comb begin
    vis           = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    hsync_d       = ((hcnt_q >= HS_START) && (hcnt_q < HS_END)) ? HS_LVL : ~HS_LVL;
    vsync_d       = ((vcnt_q >= VS_START) && (vcnt_q < VS_END)) ? VS_LVL : ~VS_LVL;
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    in_bar        = (hcnt_q >= pos_q) && ({1'b0, hcnt_q} < pos_hi);
    // Leftover pixels past 8*BAR_W fall into bar 7
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt_q >= CW'(k * BAR_W)) bar_idx = 3'(k);
    end
    rgb_d = C_BLACK;
    case (mode_q)
      3'd0:    rgb_d = vcnt_q[STRIPE_SHIFT] ? C_RED : C_BLACK;
      3'd1:    rgb_d = hcnt_q[STRIPE_SHIFT] ? C_GREEN : C_BLACK;
      3'd2:    rgb_d = bar_colour(bar_idx);
      3'd3:    rgb_d = (hcnt_q[STRIPE_SHIFT] ^ vcnt_q[STRIPE_SHIFT]) ? C_WHITE : C_BLACK;
      3'd4:    rgb_d = in_bar ? C_WHITE : C_BLUE;
      default: rgb_d = C_BLACK;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((hcnt_q == '0) || (hcnt_q == H_VIS - CW'(1)) ||
        (vcnt_q == '0) || (vcnt_q == V_VIS - CW'(1)))
      rgb_d = C_WHITE;
`endif
    if (!vis) rgb_d = C_BLACK;
  end

  // Frame-level state registers; reset wins over counting and latching
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (clr) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      mode_q <= '0;
      pos_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

  // Output registers, one clock behind the counters
  always_ff @(posedge clk) begin
    if (clr) begin
      hsync_q       <= ~HS_LVL;
      vsync_q       <= ~VS_LVL;
      rgb_q         <= C_BLACK;
      vidon_q       <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      vidon_q       <= vis;
      hc_q          <= hcnt_q;
      vc_q          <= vcnt_q;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[7:5];
  assign green       = rgb_q[4:2];
  assign blue        = rgb_q[1:0];
  assign vidon       = vidon_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: a reduced-size main instance for patterns
// and sync timing, and a tiny instance for the mid-frame reset case.
module tb_vga_pattern_gen;

  localparam int TH = 84;       // 68+4+8+4
  localparam int TV = 31;       // 24+2+2+3
  localparam int FR = TH * TV;  // 2604 clocks per frame
  localparam int BOUND = FR + 20;

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [7:0] BORDER_EXP = 8'hFF;
`else
  localparam logic [7:0] BORDER_EXP = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, clr_s;
  logic [2:0] mode, mode_s;

  logic       hsync, vsync, vidon, frame_start;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [9:0] hc, vc;

  logic       hsync_s, vsync_s, vidon_s, frame_start_s;
  logic [2:0] red_s, green_s;
  logic [1:0] blue_s;
  logic [9:0] hc_s, vc_s;

  vga_pattern_gen #(
    .H_VISIBLE(68), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(24), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(0), .VS_POL(0), .STRIPE_SHIFT(3), .STEP(16), .CW(10)
  ) dut (
    .clk(clk), .clr(clr), .mode(mode),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .vidon(vidon), .hc(hc), .vc(vc), .frame_start(frame_start)
  );

  vga_pattern_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .STRIPE_SHIFT(4), .STEP(4), .CW(10)
  ) dut_s (
    .clk(clk), .clr(clr_s), .mode(mode_s),
    .hsync(hsync_s), .vsync(vsync_s), .red(red_s), .green(green_s), .blue(blue_s),
    .vidon(vidon_s), .hc(hc_s), .vc(vc_s), .frame_start(frame_start_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [7:0] rgb();
    return {red, green, blue};
  endfunction

  function automatic logic [7:0] rgb_small();
    return {red_s, green_s, blue_s};
  endfunction

  // Advance to the next sample showing a frame_start pulse
  task automatic wait_fs(input bit s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s ? frame_start_s : frame_start) && n < BOUND);
    if (n >= BOUND) timeout("wait_fs");
  endtask

  // Advance to the next sample whose output position is (h,v)
  task automatic wait_pix(input bit s, input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(s ? hc_s : hc) == h && int'(s ? vc_s : vc) == v) && n < BOUND);
    if (n >= BOUND) timeout($sformatf("wait_pix %0d,%0d", h, v));
  endtask

  task automatic set_mode(input logic [2:0] m);
    mode = m;
    wait_fs(1'b0);
  endtask

  task automatic pix(input string name, input int h, input int v, input logic [7:0] exp);
    wait_pix(1'b0, h, v);
    check(name, rgb(), exp);
  endtask

  typedef struct {
    logic [2:0] mode;
    int         h;
    int         v;
    logic [7:0] rgb;
    logic       vid;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic add(input logic [2:0] m, input int h, input int v,
                     input logic [7:0] c, input logic vid);
    vecs[nv] = '{m, h, v, c, vid};
    nv++;
  endtask

  initial begin
    logic [2:0] cur;
    int hs_low, vs_low, vis_cnt, first_hs_hc, first_vs_vc;

    // Vectors in scan order within each mode (W = 8, BAR_W = 8)
    add(3'd0,  5,  7, 8'h00, 1'b1);
    add(3'd0,  5,  8, 8'hE0, 1'b1);
    add(3'd0, 68,  8, 8'h00, 1'b0);
    add(3'd0,  5, 15, 8'hE0, 1'b1);
    add(3'd0,  5, 16, 8'h00, 1'b1);
    add(3'd0,  5, 24, 8'h00, 1'b0);
    add(3'd1,  7,  3, 8'h00, 1'b1);
    add(3'd1,  8,  3, 8'h1C, 1'b1);
    add(3'd1, 16,  3, 8'h00, 1'b1);
    add(3'd2,  7,  5, 8'hFF, 1'b1);
    add(3'd2,  8,  5, 8'hFC, 1'b1);
    add(3'd2, 16,  5, 8'h1F, 1'b1);
    add(3'd2, 24,  5, 8'h1C, 1'b1);
    add(3'd2, 32,  5, 8'hE3, 1'b1);
    add(3'd2, 40,  5, 8'hE0, 1'b1);
    add(3'd2, 48,  5, 8'h03, 1'b1);
    add(3'd2, 55,  5, 8'h03, 1'b1);
    add(3'd2, 56,  5, 8'h00, 1'b1);
    add(3'd2, 66,  5, 8'h00, 1'b1);
    add(3'd3,  3,  3, 8'h00, 1'b1);
    add(3'd3,  8,  3, 8'hFF, 1'b1);
    add(3'd3,  1,  8, 8'hFF, 1'b1);
    add(3'd3,  8,  8, 8'h00, 1'b1);
    add(3'd5,  3, 10, 8'h00, 1'b1);
    add(3'd7,  3, 10, 8'h00, 1'b1);

    // Reset: three clocks high, then release
    clr = 1'b1; clr_s = 1'b1; mode = 3'd0; mode_s = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst hsync", hsync, 1'b1);
    check("rst vsync", vsync, 1'b1);
    check("rst rgb", rgb(), 8'h00);
    check("rst vidon", vidon, 1'b0);
    check("rst hc", hc, 10'd0);
    check("rst vc", vc, 10'd0);
    check("rst frame_start", frame_start, 1'b0);
    clr = 1'b0; clr_s = 1'b0;
    @(posedge clk); #1;
    check("rel hc", hc, 10'd0);
    check("rel vc", vc, 10'd0);
    check("rel vidon", vidon, 1'b1);
    check("rel frame_start", frame_start, 1'b1);
    check("rel rgb", rgb(), BORDER_EXP);

    // One full frame of sync/visibility statistics
    wait_fs(1'b0);
    hs_low = 0; vs_low = 0; vis_cnt = 0; first_hs_hc = -1; first_vs_vc = -1;
    for (int i = 0; i < FR; i++) begin
      if (!hsync) begin
        hs_low++;
        if (first_hs_hc < 0) first_hs_hc = int'(hc);
      end
      if (!vsync) begin
        vs_low++;
        if (first_vs_vc < 0) first_vs_vc = int'(vc);
      end
      if (vidon) vis_cnt++;
      @(negedge clk);
    end
    check("hsync low clocks/frame", hs_low, 248);
    check("vsync low clocks", vs_low, 168);
    check("vidon clocks/frame", vis_cnt, 1632);
    check("hsync start hc", first_hs_hc, 72);
    check("vsync start vc", first_vs_vc, 26);
    check("frame_start period", frame_start, 1'b1);

    // Table-driven pattern vectors
    cur = 3'd0;
    for (int i = 0; i < nv; i++) begin
      if (vecs[i].mode != cur) begin
        set_mode(vecs[i].mode);
        cur = vecs[i].mode;
      end
      wait_pix(1'b0, vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d rgb", i), rgb(), vecs[i].rgb);
      check($sformatf("vec%0d vidon", i), vidon, vecs[i].vid);
    end

    // Mid-frame mode change only takes effect at the next frame
    set_mode(3'd0);
    wait_pix(1'b0, 10, 12);
    mode = 3'd3;
    pix("midframe stripes v13", 3, 13, 8'hE0);
    pix("midframe stripes v17", 8, 17, 8'h00);
    wait_fs(1'b0);
    pix("checker (8,0)", 8, 0, 8'hFF);
    pix("checker (3,9)", 3, 9, 8'hFF);

    // Moving bar: pos advances by 16 each frame from reset, wrapping at 68
    mode = 3'd4;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    wait_fs(1'b0);              // frame 0, mode still 0
    wait_fs(1'b0);              // frame 1, pos 16
    pix("bar16 h15", 15, 3, 8'h03);
    pix("bar16 h16", 16, 3, 8'hFF);
    pix("bar16 h23", 23, 3, 8'hFF);
    pix("bar16 h24", 24, 3, 8'h03);
    repeat (3) wait_fs(1'b0);   // frame 4, pos 64
    pix("bar64 h63", 63, 5, 8'h03);
    pix("bar64 h64", 64, 5, 8'hFF);
    pix("bar64 h67", 67, 5, 8'hFF);
    pix("bar64 clip h68", 68, 5, 8'h00);
    check("bar64 clip vidon", vidon, 1'b0);
    wait_fs(1'b0);              // frame 5, pos 80-68 = 12
    pix("bar12 h11", 11, 5, 8'h03);
    pix("bar12 h12", 12, 5, 8'hFF);
    pix("bar12 h19", 19, 5, 8'hFF);
    pix("bar12 h20", 20, 5, 8'h03);

    // Tiny instance: reset pulsed mid-frame at (3,2)
    wait_pix(1'b1, 3, 2);
    clr_s = 1'b1;
    @(negedge clk);
    check("s rst hc", hc_s, 10'd0);
    check("s rst vc", vc_s, 10'd0);
    check("s rst vidon", vidon_s, 1'b0);
    check("s rst hsync", hsync_s, 1'b1);
    check("s rst frame_start", frame_start_s, 1'b0);
    clr_s = 1'b0;
    @(negedge clk);
    check("s rel hc", hc_s, 10'd0);
    check("s rel vc", vc_s, 10'd0);
    check("s rel frame_start", frame_start_s, 1'b1);
    @(negedge clk);
    check("s next hc", hc_s, 10'd1);
    check("s next frame_start", frame_start_s, 1'b0);
    wait_fs(1'b1);              // frame 1, mode 7 latched
    wait_pix(1'b1, 0, 1);
    check("s mode7 (0,1)", rgb_small(), BORDER_EXP);
    wait_pix(1'b1, 1, 1);
    check("s mode7 (1,1)", rgb_small(), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor of the stripes display path: one block containing the VGA timing counters, sync generation and a multi-mode test-pattern generator.
- Drives 8-bit RGB (3-3-2) straight to the VGA connector.
- Modes are selectable at run time and change only on frame boundaries.
- One mode is animated (a moving bar), so the block carries frame-to-frame state.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync
- STRIPE_SHIFT, 4, stripe/checker/moving-bar size = 2^STRIPE_SHIFT pixels
- STEP, 4, moving-bar advance per frame (pixels, < H_VISIBLE)
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock (25 MHz at defaults)
- clr  in  1  synchronous active-high reset
- mode  in  3  pattern select, sampled once per frame
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  3  red intensity
- green  out  3  green intensity
- blue  out  2  blue intensity
- vidon  out  1  high while the output pixel is in the visible area
- hc  out  CW  horizontal position of the output pixel
- vc  out  CW  vertical position of the output pixel
- frame_start  out  1  one-cycle pulse when the output pixel is (0,0)

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Internal counters: hcnt runs 0..H_TOTAL-1 and wraps to 0. vcnt increments when hcnt wraps, runs 0..V_TOTAL-1 and wraps to 0. Coordinate (0,0) is the first visible pixel.
- Sync:
  - hsync is active when H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC.
  - vsync is active when V_VISIBLE+V_FP <= vcnt < V_VISIBLE+V_FP+V_SYNC.
- Visible area: vis = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- Latency: every output is registered and lags the internal counters by exactly 1 clock. All outputs are mutually aligned.
- RGB is 0 whenever vis = 0.
- Mode latch: mode_q <= mode on the cycle where hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1. Mid-frame changes on mode are ignored until that point.
- Moving-bar position pos (0..H_VISIBLE-1) updates on the same cycle as the mode latch: sum = pos+STEP; pos <= (sum >= H_VISIBLE) ? sum-H_VISIBLE : sum.
- Patterns, all for visible pixels (W = 2^STRIPE_SHIFT):
  - 0, horizontal stripes: red = 7 if vcnt[STRIPE_SHIFT] = 1, else black.
  - 1, vertical stripes: green = 7 if hcnt[STRIPE_SHIFT] = 1, else black.
  - 2, eight colour bars: BAR_W = H_VISIBLE/8 (integer). Bar k covers k*BAR_W <= hcnt < (k+1)*BAR_W; any remainder pixels belong to bar 7. Colours are white, yellow, cyan, green, magenta, red, blue, black. Full levels: 7 for red and green, 3 for blue.
  - 3, checkerboard: white if hcnt[STRIPE_SHIFT] ^ vcnt[STRIPE_SHIFT], else black.
  - 4, moving bar: white if pos <= hcnt < pos+W, else blue = 3. The bar is clipped at the right edge; it does not wrap.
  - 5–7: black.
- Reset (clr = 1 at a clock edge):
  - hcnt, vcnt, pos and mode_q go to 0.
  - The outputs take these values on that edge: hsync = ~HS_POL, vsync = ~VS_POL, RGB = 0, vidon = 0, hc = 0, vc = 0, frame_start = 0.
  - Reset mid-frame restarts the timing cleanly.
  - The first clock after reset release presents pixel (0,0) with frame_start = 1 and mode_q = 0.
- Reset has priority over counting and latching.

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- When defined: a 1-pixel white border (RGB = 7,7,3) overrides every mode, including modes 5–7. Border pixels are hcnt = 0, hcnt = H_VISIBLE-1, vcnt = 0 and vcnt = V_VISIBLE-1, all within the visible area. Latency is unchanged.
- When undefined: no border logic exists, and pattern output is exactly as specified above.

Test Plan:
- Hold clr high for 3 clocks, then release → during reset hsync = 1, vsync = 1, RGB = 0, vidon = 0. First cycle after release: hc = 0, vc = 0, vidon = 1, frame_start = 1.
- Default parameters → hsync low for 96 clocks per line, line period 800 clocks. vsync low for 2 lines (1600 clocks). frame_start period 420000 clocks.
- mode = 0 → at vc = 15 red = 0; at vc = 16 red = 7; at hc = 640 RGB = 0. mode = 2 → hc = 79 is white (7,7,3); hc = 80 is yellow (7,7,0).
- Change mode from 0 to 3 at hc = 100, vc = 200 → the remainder of the frame stays horizontal stripes. The checkerboard starts at the next frame_start; pixel (16,0) is white.
- mode = 4, STEP = 4, pos = 636 → next frame pos = 0. The bar drawn at pos = 636 is clipped at hc = 639.
- Small-parameter sim (H_VISIBLE = 8, porches 1/2/1, V_VISIBLE = 4, porches 1/1/1), with clr pulsed at hc = 3, vc = 2 → the counters restart at (0,0). With VGA_PATTERN_BORDER_EN defined, pixel (0,1) is white in mode 7.
